// File: rtl/ram_bist_sequencer.sv
// Memory BIST sequencer: fills every RAM word with an address-derived pattern, reads it
// back through a READ_LATENCY-deep compare pipeline and reports pass, first failing address and count.
module ram_bist_sequencer #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  pattern_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ADDR_WIDTH:0]   fail_count,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [1:0]            DRAIN_LAST = 2'(READ_LATENCY - 1);
  localparam int                    PIPE_W     = READ_LATENCY * ADDR_WIDTH;

  state_t                  state, state_n;
  logic                    sel, sel_n;
  logic [1:0]              drain_cnt, drain_cnt_n;
  logic                    busy_n, done_n, pass_n, wren_n, mismatch;
  logic [ADDR_WIDTH-1:0]   fail_addr_n, address_n;
  logic [ADDR_WIDTH:0]     fail_count_n;
  logic [DATA_WIDTH-1:0]   data_n;
  // Bit/slot 0 holds the newest read issue; slot READ_LATENCY-1 lines up with ram_q.
  logic [READ_LATENCY-1:0]                 pipe_vld;
  logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic s, input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] v;
    v = s ? a : ~a;
    return DATA_WIDTH'(v);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sel         <= 1'b0;
      drain_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_count  <= '0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      pipe_vld    <= '0;
      pipe_addr   <= '0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      drain_cnt   <= drain_cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      fail_addr   <= fail_addr_n;
      fail_count  <= fail_count_n;
      ram_wren    <= wren_n;
      ram_address <= address_n;
      ram_data    <= data_n;
      pipe_vld    <= READ_LATENCY'({pipe_vld, state == READ});
      pipe_addr   <= PIPE_W'({pipe_addr, ram_address});
    end
  end

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    drain_cnt_n  = drain_cnt;
    busy_n       = busy;
    done_n       = 1'b0;
    pass_n       = pass;
    wren_n       = ram_wren;
    address_n    = ram_address;
    data_n       = ram_data;
    mismatch     = pipe_vld[READ_LATENCY-1] &&
                   (ram_q != pattern(sel, pipe_addr[READ_LATENCY-1]));
    fail_count_n = fail_count + (ADDR_WIDTH+1)'(mismatch);
    fail_addr_n  = (mismatch && fail_count == '0) ? pipe_addr[READ_LATENCY-1] : fail_addr;

    case (state)
      IDLE: begin
        if (start) begin
          state_n      = WRITE;
          sel_n        = pattern_sel;
          pass_n       = 1'b0;
          fail_addr_n  = '0;
          fail_count_n = '0;
          busy_n       = 1'b1;
          wren_n       = 1'b1;
          address_n    = '0;
          data_n       = pattern(pattern_sel, '0);
        end
      end
      WRITE: begin
        if (ram_address == LAST_ADDR) begin
          state_n   = READ;
          wren_n    = 1'b0;
          address_n = '0;
        end else begin
          address_n = ram_address + ADDR_WIDTH'(1);
          data_n    = pattern(sel, ram_address + ADDR_WIDTH'(1));
        end
      end
      READ: begin
        if (ram_address == LAST_ADDR) begin
          state_n     = DRAIN;
          drain_cnt_n = '0;
        end else begin
          address_n = ram_address + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        // The last compare lands on this edge, so pass must see the updated count.
        if (drain_cnt == DRAIN_LAST) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (fail_count_n == '0);
        end else begin
          drain_cnt_n = drain_cnt + 2'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
